fetch_unit: RTL and testbench

Instruction fetch stage: the producer side of the fetch→decode pipeline interface. Owns the PC, issues single-outstanding requests to instruction memory, and presents PC, instruction word, exception code/valid and `pipeline_out_valid` to decode. Honours decode-side `stall` with a one-entry holding buffer and redirects on `flush`.

---
 rtl/fetch_unit_if.sv | 33 +++
 rtl/fetch_unit.sv | 200 ++++++++++++++++++++
 tb/tb_fetch_unit.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bundles the instruction-memory request/response bus and the
// fetch-to-decode output slot (with its decode-side stall) into one interface.
// master = fetch stage, slave = memory plus decode.
interface fetch_unit_if #(
    parameter int EX_W = 4
);
    logic            imem_req;
    logic [31:0]     imem_addr;
    logic            imem_ack;
    logic [31:0]     imem_rdata;
    logic            imem_err;

    logic            stall;
    logic [31:0]     PC_out;
    logic [31:0]     instr_out;
    logic [EX_W-1:0] exception_out;
    logic            exception_out_valid;
    logic            pipeline_out_valid;

    modport master (
        output imem_req, imem_addr,
        output PC_out, instr_out, exception_out, exception_out_valid, pipeline_out_valid,
        input  imem_ack, imem_rdata, imem_err,
        input  stall
    );

    modport slave (
        input  imem_req, imem_addr,
        input  PC_out, instr_out, exception_out, exception_out_valid, pipeline_out_valid,
        output imem_ack, imem_rdata, imem_err,
        output stall
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, keeps at most one request
// outstanding to instruction memory, and presents one entry at a time to decode.
// A one-entry holding buffer absorbs a response that lands while decode stalls.
//
// Optional feature macro: FETCH_MISALIGN_CHK_EN
//   defined   : a flush to a non-word-aligned target produces one misaligned
//               exception entry and the unit then idles until the next flush.
//   undefined : redirect targets are forced to word alignment.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_REQ   | request outstanding at imem_addr (== pc)
// S_HOLD  | holding buffer full, decode stalled, no request
// S_DRAIN | request abandoned by flush, waiting for its ack to discard it
// S_IDLE  | stopped after a misaligned redirect (macro builds only)
module fetch_unit #(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          EX_W            = 4,
    parameter int          EX_MISALIGNED   = 0,
    parameter int          EX_ACCESS_FAULT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic [31:0]   redirect_pc,
    fetch_unit_if.master  bus
);

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [EX_W-1:0] CODE_FAULT = EX_W'(EX_ACCESS_FAULT);

    // Exception codes must fit the code field and be distinguishable.
    if (EX_W < 1 || EX_MISALIGNED < 0 || EX_ACCESS_FAULT < 0 ||
        EX_MISALIGNED >= (1 << EX_W) || EX_ACCESS_FAULT >= (1 << EX_W) ||
        EX_MISALIGNED == EX_ACCESS_FAULT) begin : g_bad_codes
        $error("fetch_unit: exception codes invalid for EX_W");
    end

`ifdef FETCH_MISALIGN_CHK_EN
    localparam logic [EX_W-1:0] CODE_MIS = EX_W'(EX_MISALIGNED);
    typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2, S_IDLE = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_REQ = 2'd0, S_HOLD = 2'd1, S_DRAIN = 2'd2} state_t;
`endif

    state_t          state;
    logic [31:0]     pc;
    logic [31:0]     addr;

    logic            out_valid;
    logic [31:0]     out_pc;
    logic [31:0]     out_instr;
    logic [EX_W-1:0] out_exc;
    logic            out_exv;

    // Buffer contents are meaningful only while in S_HOLD.
    logic [31:0]     hold_pc;
    logic [31:0]     hold_instr;
    logic [EX_W-1:0] hold_exc;
    logic            hold_exv;

    logic            slot_free;
    logic            req_active;
    logic [31:0]     rsp_instr;
    logic [EX_W-1:0] rsp_exc;
    logic [31:0]     flush_pc;
    logic            flush_mis;

    // Response shaping, slot availability and redirect target.
    always_comb begin
        slot_free  = !out_valid || !bus.stall;
        req_active = (state == S_REQ) || (state == S_DRAIN);
        rsp_instr  = bus.imem_err ? NOP : bus.imem_rdata;
        rsp_exc    = bus.imem_err ? CODE_FAULT : '0;
`ifdef FETCH_MISALIGN_CHK_EN
        flush_pc   = redirect_pc;
        flush_mis  = |redirect_pc[1:0];
`else
        flush_pc   = redirect_pc & 32'hFFFF_FFFC;
        flush_mis  = 1'b0;
`endif
    end

    // Request is combinational on state so the first request appears as soon
    // as reset drops; address is registered and stable for the whole request.
    assign bus.imem_req            = !reset && req_active;
    assign bus.imem_addr           = addr;
    assign bus.PC_out              = out_pc;
    assign bus.instr_out           = out_instr;
    assign bus.exception_out       = out_exc;
    assign bus.exception_out_valid = out_exv;
    assign bus.pipeline_out_valid  = out_valid;

    // Fetch FSM with the output slot and holding buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_REQ;
            pc         <= RESET_PC;
            addr       <= RESET_PC;
            out_valid  <= 1'b0;
            out_pc     <= 32'h0;
            out_instr  <= NOP;
            out_exc    <= '0;
            out_exv    <= 1'b0;
            hold_pc    <= 32'h0;
            hold_instr <= NOP;
            hold_exc   <= '0;
            hold_exv   <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
            pc        <= flush_pc;
            if (req_active && !bus.imem_ack) begin
                // Address stays on the old request until memory answers it.
                state <= S_DRAIN;
`ifdef FETCH_MISALIGN_CHK_EN
            end else if (flush_mis) begin
                out_valid <= 1'b1;
                out_pc    <= flush_pc;
                out_instr <= NOP;
                out_exc   <= CODE_MIS;
                out_exv   <= 1'b1;
                state     <= S_IDLE;
`endif
            end else begin
                addr  <= flush_pc;
                state <= S_REQ;
            end
        end else begin
            case (state)
                S_REQ: begin
                    if (bus.imem_ack) begin
                        pc   <= pc + 32'd4;
                        addr <= pc + 32'd4;
                        if (slot_free) begin
                            out_valid <= 1'b1;
                            out_pc    <= pc;
                            out_instr <= rsp_instr;
                            out_exc   <= rsp_exc;
                            out_exv   <= bus.imem_err;
                        end else begin
                            hold_pc    <= pc;
                            hold_instr <= rsp_instr;
                            hold_exc   <= rsp_exc;
                            hold_exv   <= bus.imem_err;
                            state      <= S_HOLD;
                        end
                    end else if (slot_free) begin
                        out_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (!bus.stall) begin
                        out_valid <= 1'b1;
                        out_pc    <= hold_pc;
                        out_instr <= hold_instr;
                        out_exc   <= hold_exc;
                        out_exv   <= hold_exv;
                        state     <= S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (slot_free) begin
                        out_valid <= 1'b0;
                    end
                    if (bus.imem_ack) begin
`ifdef FETCH_MISALIGN_CHK_EN
                        if (|pc[1:0]) begin
                            out_valid <= 1'b1;
                            out_pc    <= pc;
                            out_instr <= NOP;
                            out_exc   <= CODE_MIS;
                            out_exv   <= 1'b1;
                            state     <= S_IDLE;
                        end else begin
                            addr  <= pc;
                            state <= S_REQ;
                        end
`else
                        addr  <= pc;
                        state <= S_REQ;
`endif
                    end
                end
`ifdef FETCH_MISALIGN_CHK_EN
                S_IDLE: begin
                    if (slot_free) begin
                        out_valid <= 1'b0;
                    end
                end
`endif
                default: state <= S_REQ;
            endcase
        end
    end

    // flush_mis only steers the macro build; keep it observed in both builds.
    logic unused_ok;
    assign unused_ok = flush_mis;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed vector table for fetch_unit plus hand-written
// sequences for reset mid-request, double flush during drain and drain ack.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] redirect_pc;
    logic        stall_in;
    logic        autom;
    logic        ack_man;
    logic        err_in;

    int total;
    int bad;

    fetch_unit_if #(.EX_W(4)) bus ();

    // Memory: zero-wait (ack follows req) or manually acked; data = addr+0x100.
    assign bus.imem_ack   = autom ? bus.imem_req : ack_man;
    assign bus.imem_rdata = bus.imem_addr + 32'h100;
    assign bus.imem_err   = err_in;
    assign bus.stall      = stall_in;

    fetch_unit #(
        .RESET_PC(32'h0000_0000),
        .EX_W(4),
        .EX_MISALIGNED(0),
        .EX_ACCESS_FAULT(1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .redirect_pc(redirect_pc),
        .bus(bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        rst, stl, fl;
        logic [31:0] rp;
        logic        au, ak, er;
        logic        e_pov;
        logic [31:0] e_pc, e_instr;
        logic        e_exv;
        logic [3:0]  e_exc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        chk_data, chk_addr;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic stl, input logic fl, input logic [31:0] rp,
                       input logic au, input logic ak, input logic er,
                       input logic e_pov, input logic [31:0] e_pc, input logic [31:0] e_instr,
                       input logic e_exv, input logic [3:0] e_exc,
                       input logic e_req, input logic [31:0] e_addr, input logic chk_addr);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fl = fl; v.rp = rp;
        v.au = au; v.ak = ak; v.er = er;
        v.e_pov = e_pov; v.e_pc = e_pc; v.e_instr = e_instr;
        v.e_exv = e_exv; v.e_exc = e_exc;
        v.e_req = e_req; v.e_addr = e_addr;
        v.chk_data = e_pov | rst;
        v.chk_addr = chk_addr;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic got;
        total = 0; bad = 0;
        reset = 1'b1; flush = 1'b0; redirect_pc = 32'h0;
        stall_in = 1'b0; autom = 1'b1; ack_man = 1'b0; err_in = 1'b0;

        //   rst stl fl  rp            au ak er  pov pc            instr         exv exc  req addr         chka
        add(1, 0, 0, 32'h0,          1, 0, 0,  0, 32'h0,         32'h13,        0, 0,   0, 32'h0,        1);
        add(1, 0, 0, 32'h0,          1, 0, 0,  0, 32'h0,         32'h13,        0, 0,   0, 32'h0,        1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h0,         32'h100,       0, 0,   1, 32'h4,        1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h4,         32'h104,       0, 0,   1, 32'h8,        1);
        add(0, 1, 0, 32'h0,          1, 0, 0,  1, 32'h4,         32'h104,       0, 0,   0, 32'hC,        1);
        add(0, 1, 0, 32'h0,          1, 0, 0,  1, 32'h4,         32'h104,       0, 0,   0, 32'hC,        1);
        add(0, 1, 0, 32'h0,          1, 0, 0,  1, 32'h4,         32'h104,       0, 0,   0, 32'hC,        1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h8,         32'h108,       0, 0,   1, 32'hC,        1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'hC,         32'h10C,       0, 0,   1, 32'h10,       1);
        add(0, 0, 0, 32'h0,          1, 0, 1,  1, 32'h10,        32'h13,        1, 1,   1, 32'h14,       1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h14,        32'h114,       0, 0,   1, 32'h18,       1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h18,        32'h118,       0, 0,   1, 32'h1C,       1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h1C,        32'h11C,       0, 0,   1, 32'h20,       1);
        add(0, 0, 0, 32'h0,          0, 0, 0,  0, 32'h0,         32'h0,         0, 0,   1, 32'h20,       1);
        add(0, 0, 1, 32'h200,        0, 0, 0,  0, 32'h0,         32'h0,         0, 0,   1, 32'h20,       1);
        add(0, 0, 0, 32'h0,          0, 0, 0,  0, 32'h0,         32'h0,         0, 0,   1, 32'h20,       1);
        add(0, 0, 0, 32'h0,          0, 1, 0,  0, 32'h0,         32'h0,         0, 0,   1, 32'h200,      1);
        add(0, 0, 0, 32'h0,          0, 1, 0,  1, 32'h200,       32'h300,       0, 0,   1, 32'h204,      1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h204,       32'h304,       0, 0,   1, 32'h208,      1);
        add(0, 0, 1, 32'hFFFF_FFFC,  1, 0, 0,  0, 32'h0,         32'h0,         0, 0,   1, 32'hFFFF_FFFC, 1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'hFFFF_FFFC, 32'h0000_00FC, 0, 0,   1, 32'h0,        1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h0,         32'h100,       0, 0,   1, 32'h4,        1);
`ifdef FETCH_MISALIGN_CHK_EN
        add(0, 0, 1, 32'h202,        1, 0, 0,  1, 32'h202,       32'h13,        1, 0,   0, 32'h0,        0);
        add(0, 1, 0, 32'h0,          1, 0, 0,  1, 32'h202,       32'h13,        1, 0,   0, 32'h0,        0);
        add(0, 0, 0, 32'h0,          1, 0, 0,  0, 32'h0,         32'h0,         0, 0,   0, 32'h0,        0);
        add(0, 0, 0, 32'h0,          1, 0, 0,  0, 32'h0,         32'h0,         0, 0,   0, 32'h0,        0);
`else
        add(0, 0, 1, 32'h202,        1, 0, 0,  0, 32'h0,         32'h0,         0, 0,   1, 32'h200,      1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h200,       32'h300,       0, 0,   1, 32'h204,      1);
        add(0, 1, 0, 32'h0,          1, 0, 0,  1, 32'h200,       32'h300,       0, 0,   0, 32'h208,      1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h204,       32'h304,       0, 0,   1, 32'h208,      1);
`endif
        add(0, 0, 1, 32'h300,        1, 0, 0,  0, 32'h0,         32'h0,         0, 0,   1, 32'h300,      1);
        add(0, 0, 0, 32'h0,          1, 0, 0,  1, 32'h300,       32'h400,       0, 0,   1, 32'h304,      1);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst; stall_in = vecs[i].stl; flush = vecs[i].fl;
            redirect_pc = vecs[i].rp; autom = vecs[i].au; ack_man = vecs[i].ak;
            err_in = vecs[i].er;
            tick();
            check($sformatf("r%0d.valid", i), 32'(bus.pipeline_out_valid), 32'(vecs[i].e_pov));
            check($sformatf("r%0d.req", i), 32'(bus.imem_req), 32'(vecs[i].e_req));
            if (vecs[i].chk_addr)
                check($sformatf("r%0d.addr", i), bus.imem_addr, vecs[i].e_addr);
            if (vecs[i].chk_data) begin
                check($sformatf("r%0d.pc", i), bus.PC_out, vecs[i].e_pc);
                check($sformatf("r%0d.instr", i), bus.instr_out, vecs[i].e_instr);
                check($sformatf("r%0d.exv", i), 32'(bus.exception_out_valid), 32'(vecs[i].e_exv));
                check($sformatf("r%0d.exc", i), 32'(bus.exception_out), 32'(vecs[i].e_exc));
            end
        end

        // Reset while a request is outstanding.
        @(negedge clk);
        autom = 1'b0; ack_man = 1'b0; stall_in = 1'b0; flush = 1'b0; err_in = 1'b0;
        tick();
        check("mid.req", 32'(bus.imem_req), 32'h1);
        check("mid.addr", bus.imem_addr, 32'h304);
        @(negedge clk); reset = 1'b1;
        tick();
        check("rst.req", 32'(bus.imem_req), 32'h0);
        check("rst.valid", 32'(bus.pipeline_out_valid), 32'h0);
        check("rst.addr", bus.imem_addr, 32'h0);
        @(negedge clk); reset = 1'b0;
        #1;
        check("rel.req", 32'(bus.imem_req), 32'h1);
        tick();
        check("noack.addr", bus.imem_addr, 32'h0);

        // Two flushes while draining: only the last target survives.
        @(negedge clk); flush = 1'b1; redirect_pc = 32'h40;
        tick();
        check("drain1.req", 32'(bus.imem_req), 32'h1);
        check("drain1.addr", bus.imem_addr, 32'h0);
        @(negedge clk); redirect_pc = 32'h80;
        tick();
        check("drain2.addr", bus.imem_addr, 32'h0);
        @(negedge clk); flush = 1'b0; ack_man = 1'b1;
        tick();
        check("drained.addr", bus.imem_addr, 32'h80);
        check("drained.valid", 32'(bus.pipeline_out_valid), 32'h0);
        got = 1'b0;
        for (int c = 0; c < 4 && !got; c++) begin
            tick();
            got = bus.pipeline_out_valid;
        end
        check("redir.arrived", 32'(got), 32'h1);
        check("redir.pc", bus.PC_out, 32'h80);
        check("redir.instr", bus.instr_out, 32'h180);
        @(negedge clk); ack_man = 1'b0;
        tick();
        check("gap.valid", 32'(bus.pipeline_out_valid), 32'h0);
        check("gap.addr", bus.imem_addr, 32'h84);

        // Flush to an unaligned target while a request is in flight.
        @(negedge clk); flush = 1'b1; redirect_pc = 32'h306;
        tick();
        check("ua.drain.addr", bus.imem_addr, 32'h84);
        check("ua.drain.valid", 32'(bus.pipeline_out_valid), 32'h0);
        @(negedge clk); flush = 1'b0; ack_man = 1'b1;
        tick();
`ifdef FETCH_MISALIGN_CHK_EN
        check("ua.valid", 32'(bus.pipeline_out_valid), 32'h1);
        check("ua.pc", bus.PC_out, 32'h306);
        check("ua.exv", 32'(bus.exception_out_valid), 32'h1);
        check("ua.exc", 32'(bus.exception_out), 32'h0);
        check("ua.req", 32'(bus.imem_req), 32'h0);
`else
        check("ua.valid", 32'(bus.pipeline_out_valid), 32'h0);
        check("ua.addr", bus.imem_addr, 32'h304);
        check("ua.req", 32'(bus.imem_req), 32'h1);
`endif
        @(negedge clk); ack_man = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
